sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Owns the single external asynchronous SRAM (256K x 16) and sits directly upstream of the LCD controller.
- Serves the LCD controller's 4-read pixel frames with fixed 2-cycle latency, and returns 15-bit RGB data on RdQ.
- Drains a write FIFO, fed by the spectrum bar renderer, into the idle bus slots between read frames.
- Read frames are never delayed. Writes yield unconditionally.

Parameters:
FIFO_AW, 3, log2 of write-FIFO depth (default 8 entries)
RD_SLOTS, 4, reads per frame (L, R, L+1, R+1); fixed, not tested at other values

Ports:
Clock  in  1  system clock
Reset  in  1  asynchronous, active-high
FrameStart  in  1  one-cycle pulse from LCD controller; read addresses follow on the next RD_SLOTS cycles
RdAddr  in  18  LCD read address; [17] screen, [16] L/R, [15:9] y, [8:0] x
RdQ  out  15  read data; data for RdAddr sampled in cycle n is valid in cycle n+2
WrValid  in  1  write request from renderer
WrAddr  in  18  write address, same map as RdAddr
WrData  in  15  RGB555 pixel
WrReady  out  1  FIFO not full; a push happens on WrValid & WrReady
OvlErr  out  1  sticky: FrameStart arrived while a window was active
SRAM_A  out  18  SRAM address pins (registered)
SRAM_DQ_O  out  16  write data; bit 15 driven 0
SRAM_DQ_OE  out  1  drive enable for the DQ pads
SRAM_DQ_I  in  16  pad input data
SRAM_nCE  out  1  chip enable, active low
SRAM_nOE  out  1  output enable, active low
SRAM_nWE  out  1  write enable, active low

Behaviour:
- Reset values: RdQ=0, WrReady=0, OvlErr=0, SRAM_A=0, SRAM_DQ_O=0, SRAM_DQ_OE=0, SRAM_nCE=1, SRAM_nOE=1, SRAM_nWE=1. FIFO is emptied.
- In the first cycle after reset: nCE=0 (held thereafter) and WrReady=1.
- All SRAM pin outputs are registered. The bus state in cycle n+1 is decided in cycle n.
- Window counter WC (0..RD_SLOTS+1), 0 = idle:
  - FrameStart sets WC=1.
  - WC=1..RD_SLOTS: read slots.
  - WC=RD_SLOTS+1: turnaround slot, no bus drive.
  - The counter then returns to 0.
- FSM states:
  - IDLE: WC=0.
  - READ: WC in 1..RD_SLOTS. Pins: A=RdAddr registered, nOE=0, nWE=1, DQ_OE=0.
  - TURN: WC=RD_SLOTS+1. Pins: nOE=1, nWE=1, DQ_OE=0.
  - WRITE: single cycle. Pins: A=fifo head addr, DQ_O={1'b0,data}, DQ_OE=1, nOE=1, nWE=0. Returns to IDLE or READ.
- Read data path: in cycle n+1, the SRAM_A register holds the address sampled in cycle n. SRAM_DQ_I[14:0] is captured at the end of n+1 into RdQ, so RdQ is valid in cycle n+2. RdQ holds its value between frames.
- Write issue: a write is issued in cycle n+1 only if all of the following hold in cycle n:
  - FIFO is not empty,
  - WC is 0, or WC is RD_SLOTS+1 going to 0,
  - FrameStart is 0.
  The FIFO pops when the write is issued. Writes are never back-to-back with reads without a TURN slot in between.
- A FrameStart in the cycle after a WRITE is legal. The read begins immediately, because the WRITE cycle has already ended.
- FIFO:
  - Depth 2^FIFO_AW, first-in first-out.
  - Push and pop in the same cycle are both performed, and the level is unchanged.
  - WrReady=0 when full; a push while full is ignored.
  - A pop while empty cannot occur.
  - Pointer wrap-around is modulo the depth.
- Overlap: a FrameStart while WC is in 1..RD_SLOTS+1 restarts WC=1 and sets OvlErr. OvlErr is cleared only by Reset.
- Reset mid-write: the pins go to their reset values at once and the pending FIFO contents are lost.

Optional Feature:
- Macro: SRAM_BANK_SWAP_EN.
- When defined:
  - Adds input BankToggle (1-bit pulse; the LCD controller's NewFrame) and output DispBank (1-bit, reset 0).
  - DispBank toggles on BankToggle, but only while WC=0 and the FIFO is empty. Otherwise the toggle is held pending and applied at the first cycle meeting both conditions.
  - Read address bit 17 is forced to DispBank.
  - Write address bit 17 is forced to ~DispBank.
- When not defined: RdAddr and WrAddr bit 17 pass through unchanged, and there is no extra port.

Test Plan:
- Reset, then FrameStart at cycle 10 with RdAddr=0x00005, 0x10005, 0x00006, 0x10006 on cycles 11-14, and the SRAM model returning addr[14:0]:
  - nOE=0 on cycles 12-15.
  - RdQ = 0x0005, 0x0005, 0x0006, 0x0006 on cycles 13-16.
  - nWE stays 1.
- Push 3 writes (0x01234/0x7FFF, 0x01235/0x001F, 0x01236/0x03E0) with no frames: three single-cycle nWE=0 pulses in order, DQ_O bit15=0, and WrReady stays 1.
- Keep the FIFO loaded and pulse FrameStart every 8 cycles:
  - no write while WC is in 1..5, nor in the cycle after FrameStart;
  - nOE and DQ_OE are never both active;
  - all writes land in order.
- Push 9 writes while frames block the bus:
  - WrReady=0 after 8 entries and the 9th is dropped;
  - WrReady=1 the cycle after the first pop;
  - the SRAM model holds exactly the first 8 entries.
- FrameStart at cycles 10 and 12: OvlErr=1 from cycle 13, and reads continue from the restarted window. Reset at cycle 20 clears OvlErr and returns the pins to reset values asynchronously.
- With SRAM_BANK_SWAP_EN defined, pulse BankToggle during a read window with the FIFO non-empty: DispBank flips only after WC=0 and the FIFO has drained; subsequent write A[17]=~DispBank and read A[17]=DispBank.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter: owns the external 256Kx16 async SRAM. Serves the LCD controller's
// fixed-latency read frames and slips queued renderer writes into idle bus slots.
// Optional: define SRAM_BANK_SWAP_EN for display/draw bank swapping (BankToggle/DispBank).
module sram_arbiter #(
    parameter int FIFO_AW  = 3,
    parameter int RD_SLOTS = 4
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        FrameStart,
    input  logic [17:0] RdAddr,
    output logic [14:0] RdQ,
    input  logic        WrValid,
    input  logic [17:0] WrAddr,
    input  logic [14:0] WrData,
    output logic        WrReady,
    output logic        OvlErr,
`ifdef SRAM_BANK_SWAP_EN
    input  logic        BankToggle,
    output logic        DispBank,
`endif
    output logic [17:0] SRAM_A,
    output logic [15:0] SRAM_DQ_O,
    output logic        SRAM_DQ_OE,
    input  logic [15:0] SRAM_DQ_I,
    output logic        SRAM_nCE,
    output logic        SRAM_nOE,
    output logic        SRAM_nWE
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int WCW   = $clog2(RD_SLOTS + 2);
    localparam logic [WCW-1:0]     WC_LAST = WCW'(RD_SLOTS);
    localparam logic [WCW-1:0]     WC_TURN = WCW'(RD_SLOTS + 1);
    localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_TURN, S_WRITE} state_t;

    state_t              state_q, state_d;
    logic [WCW-1:0]      wc_q, wc_d;
    logic                live_q;
    logic                ovl_q, ovl_d;
    logic [14:0]         rdq_q, rdq_d;
    logic [17:0]         a_q, a_d;
    logic [15:0]         dq_o_q, dq_o_d;
    logic                dq_oe_q, dq_oe_d, nce_q, noe_q, noe_d, nwe_q, nwe_d;

    // Write FIFO: address and data stored side by side
    logic [32:0]         fifo_mem [DEPTH];
    logic [FIFO_AW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [FIFO_AW:0]    cnt_q, cnt_d;
    logic                fifo_empty, push, wr_issue;
    logic [17:0]         head_addr, rd_addr_m, wr_addr_m;
    logic [14:0]         head_data;
    logic                unused_dq15;

    assign unused_dq15 = SRAM_DQ_I[15];
    assign fifo_empty  = (cnt_q == '0);
    assign WrReady     = live_q && (cnt_q != CNT_FULL);
    assign push        = WrValid && WrReady;
    assign head_addr   = fifo_mem[rptr_q][32:15];
    assign head_data   = fifo_mem[rptr_q][14:0];
    // Writes only take slots outside a read window and never the slot a new frame claims
    assign wr_issue    = !fifo_empty && (wc_q == '0 || wc_q == WC_TURN) && !FrameStart;

`ifdef SRAM_BANK_SWAP_EN
    logic bank_q, bank_d, pend_q, pend_d, toggle;
    logic unused_bits;
    assign unused_bits = ^{head_addr[17], RdAddr[17]};
    assign rd_addr_m   = {bank_q, RdAddr[16:0]};
    assign wr_addr_m   = {~bank_q, head_addr[16:0]};
    assign DispBank    = bank_q;
    assign toggle      = BankToggle || pend_q;

    // Bank flips only when the bus is idle and no draw-bank write is still queued
    always_comb begin
        bank_d = bank_q;
        pend_d = toggle;
        if (toggle && wc_q == '0 && fifo_empty) begin
            bank_d = ~bank_q;
            pend_d = 1'b0;
        end
    end

    // Bank state registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            bank_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            bank_q <= bank_d;
            pend_q <= pend_d;
        end
    end
`else
    assign rd_addr_m = RdAddr;
    assign wr_addr_m = head_addr;
`endif

    // Window counter, phase and next pin values; pins for cycle n+1 are decided here in cycle n
    always_comb begin
        wc_d    = wc_q;
        state_d = state_q;
        ovl_d   = ovl_q || (FrameStart && wc_q != '0);
        a_d     = a_q;
        dq_o_d  = dq_o_q;
        dq_oe_d = 1'b0;
        noe_d   = 1'b1;
        nwe_d   = 1'b1;
        if (FrameStart) begin
            wc_d    = WCW'(1);
            state_d = S_READ;
        end else if (wc_q == WC_TURN || wc_q == '0) begin
            wc_d    = '0;
            state_d = wr_issue ? S_WRITE : S_IDLE;
        end else if (wc_q == WC_LAST) begin
            wc_d    = wc_q + WCW'(1);
            state_d = S_TURN;
        end else begin
            wc_d    = wc_q + WCW'(1);
            state_d = S_READ;
        end
        case (state_q)
            S_READ: begin
                a_d   = rd_addr_m;
                noe_d = 1'b0;
            end
            default: begin
                if (wr_issue) begin
                    a_d     = wr_addr_m;
                    dq_o_d  = {1'b0, head_data};
                    dq_oe_d = 1'b1;
                    nwe_d   = 1'b0;
                end
            end
        endcase
    end

    // FIFO pointers and level; simultaneous push and pop leave the level unchanged
    always_comb begin
        wptr_d = wptr_q + FIFO_AW'(push);
        rptr_d = rptr_q + FIFO_AW'(wr_issue);
        cnt_d  = cnt_q + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(wr_issue);
        // Read data is captured at the end of every cycle the SRAM drives the bus
        rdq_d  = noe_q ? rdq_q : SRAM_DQ_I[14:0];
    end

    // FIFO storage, no reset needed since the pointers define validity
    always_ff @(posedge Clock) begin
        if (push) fifo_mem[wptr_q] <= {WrAddr, WrData};
    end

    // All state and SRAM pin registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            wc_q    <= '0;
            live_q  <= 1'b0;
            ovl_q   <= 1'b0;
            rdq_q   <= '0;
            a_q     <= '0;
            dq_o_q  <= '0;
            dq_oe_q <= 1'b0;
            nce_q   <= 1'b1;
            noe_q   <= 1'b1;
            nwe_q   <= 1'b1;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wc_q    <= wc_d;
            live_q  <= 1'b1;
            ovl_q   <= ovl_d;
            rdq_q   <= rdq_d;
            a_q     <= a_d;
            dq_o_q  <= dq_o_d;
            dq_oe_q <= dq_oe_d;
            nce_q   <= 1'b0;
            noe_q   <= noe_d;
            nwe_q   <= nwe_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign RdQ        = rdq_q;
    assign OvlErr     = ovl_q;
    assign SRAM_A     = a_q;
    assign SRAM_DQ_O  = dq_o_q;
    assign SRAM_DQ_OE = dq_oe_q;
    assign SRAM_nCE   = nce_q;
    assign SRAM_nOE   = noe_q;
    assign SRAM_nWE   = nwe_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural async SRAM and a bus monitor.
module tb_sram_arbiter;
    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        FrameStart = 1'b0;
    logic [17:0] RdAddr = '0;
    logic        WrValid = 1'b0;
    logic [17:0] WrAddr = '0;
    logic [14:0] WrData = '0;
    logic [14:0] RdQ;
    logic        WrReady, OvlErr;
    logic [17:0] SRAM_A;
    logic [15:0] SRAM_DQ_O, SRAM_DQ_I;
    logic        SRAM_DQ_OE, SRAM_nCE, SRAM_nOE, SRAM_nWE;
`ifdef SRAM_BANK_SWAP_EN
    logic        BankToggle = 1'b0;
    logic        DispBank;
`endif

    int checks = 0, errors = 0;
    logic [15:0] mem [0:262143];
    logic [17:0] log_a [$];
    logic [15:0] log_d [$];
    int viol_fs = 0, viol_bus = 0, viol_b15 = 0, fs_age = 100;
    logic [17:0] ea [$];
    logic [15:0] ed [$];

    sram_arbiter dut (
        .Clock(Clock), .Reset(Reset), .FrameStart(FrameStart), .RdAddr(RdAddr), .RdQ(RdQ),
        .WrValid(WrValid), .WrAddr(WrAddr), .WrData(WrData), .WrReady(WrReady), .OvlErr(OvlErr),
`ifdef SRAM_BANK_SWAP_EN
        .BankToggle(BankToggle), .DispBank(DispBank),
`endif
        .SRAM_A(SRAM_A), .SRAM_DQ_O(SRAM_DQ_O), .SRAM_DQ_OE(SRAM_DQ_OE), .SRAM_DQ_I(SRAM_DQ_I),
        .SRAM_nCE(SRAM_nCE), .SRAM_nOE(SRAM_nOE), .SRAM_nWE(SRAM_nWE)
    );

    always #5 Clock = ~Clock;

    assign SRAM_DQ_I = mem[SRAM_A];

    // SRAM model and bus monitor, sampled mid-cycle
    initial begin
        for (int i = 0; i < 262144; i++) mem[i] = {1'b0, i[14:0]};
        forever begin
            @(negedge Clock);
            if (!SRAM_nOE && SRAM_DQ_OE) viol_bus++;
            if (!SRAM_nWE) begin
                if (fs_age < 5) viol_fs++;
                if (SRAM_DQ_O[15]) viol_b15++;
                if (!SRAM_nCE && SRAM_DQ_OE) mem[SRAM_A] = SRAM_DQ_O;
                log_a.push_back(SRAM_A);
                log_d.push_back(SRAM_DQ_O);
            end
            fs_age = FrameStart ? 0 : (fs_age < 100 ? fs_age + 1 : fs_age);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_log(input string tag, input int idx, input logic [17:0] a, input logic [15:0] d);
        chk({tag, "_a"}, (idx < log_a.size()) ? 32'(log_a[idx]) : 'x, 32'(a));
        chk({tag, "_d"}, (idx < log_d.size()) ? 32'(log_d[idx]) : 'x, 32'(d));
    endtask

    initial begin
        logic [17:0] rd_a [4];
        logic [14:0] rdq_e [6];
        logic [17:0] wa [3];
        logic [14:0] wd [3];
        int base, npush;

        // Reset values
        step(); step();
        chk("rst_rdq", 32'(RdQ), 0);       chk("rst_wrready", 32'(WrReady), 0);
        chk("rst_ovl", 32'(OvlErr), 0);    chk("rst_a", 32'(SRAM_A), 0);
        chk("rst_dqo", 32'(SRAM_DQ_O), 0); chk("rst_dqoe", 32'(SRAM_DQ_OE), 0);
        chk("rst_nce", 32'(SRAM_nCE), 1);  chk("rst_noe", 32'(SRAM_nOE), 1);
        chk("rst_nwe", 32'(SRAM_nWE), 1);
        Reset = 1'b0;
        step();
        chk("post_nce", 32'(SRAM_nCE), 0); chk("post_wrready", 32'(WrReady), 1);
        step(); step();

        // Read frame: latency and data path
        rd_a[0] = 18'h00005; rd_a[1] = 18'h10005; rd_a[2] = 18'h00006; rd_a[3] = 18'h10006;
        rdq_e[0] = 15'h0; rdq_e[1] = 15'h5; rdq_e[2] = 15'h5;
        rdq_e[3] = 15'h6; rdq_e[4] = 15'h6; rdq_e[5] = 15'h6;
        FrameStart = 1'b1;
        step();
        FrameStart = 1'b0;
        chk("rd_pre_noe", 32'(SRAM_nOE), 1);
        for (int j = 0; j < 6; j++) begin
            RdAddr = (j < 4) ? rd_a[j] : 18'h0;
            step();
            chk("rd_noe", 32'(SRAM_nOE), (j < 4) ? 0 : 1);
            if (j < 4) chk("rd_a", 32'(SRAM_A), 32'(rd_a[j]));
            chk("rd_q", 32'(RdQ), 32'(rdq_e[j]));
            chk("rd_nwe", 32'(SRAM_nWE), 1);
        end

        // Three writes with no frames, spaced so each nWE pulse stands alone
        wa[0] = 18'h01234; wa[1] = 18'h01235; wa[2] = 18'h01236;
        wd[0] = 15'h7FFF;  wd[1] = 15'h001F;  wd[2] = 15'h03E0;
        base = log_a.size();
        for (int k = 0; k < 3; k++) begin
            WrValid = 1'b1; WrAddr = wa[k]; WrData = wd[k];
            step();
            WrValid = 1'b0;
            chk("wr_ready", 32'(WrReady), 1);
            step();
            chk("wr_pulse_nwe", 32'(SRAM_nWE), 0);
            chk("wr_pulse_oe", 32'(SRAM_DQ_OE), 1);
            step();
            chk("wr_pulse_end", 32'(SRAM_nWE), 1);
            step();
        end
        chk("wr_count", 32'(log_a.size() - base), 3);
        for (int k = 0; k < 3; k++) chk_log("wr_log", base + k, wa[k], {1'b0, wd[k]});

        // Loaded FIFO against a frame every 8 cycles
        base = log_a.size();
        npush = 0;
        for (int i = 0; i < 48; i++) begin
            FrameStart = (i % 8 == 0);
            if (npush < 12 && WrReady) begin
                WrValid = 1'b1; WrAddr = 18'h02000 + 18'(npush); WrData = 15'(npush * 3 + 1);
                ea.push_back(WrAddr); ed.push_back({1'b0, WrData});
                npush++;
            end else WrValid = 1'b0;
            step();
        end
        FrameStart = 1'b0; WrValid = 1'b0;
        repeat (12) step();
        chk("mix_count", 32'(log_a.size() - base), 12);
        for (int k = 0; k < 12; k++) chk_log("mix_log", base + k, ea[k], ed[k]);
        chk("mix_viol_fs", 32'(viol_fs), 0);
        chk("mix_viol_bus", 32'(viol_bus), 0);
        chk("mix_viol_b15", 32'(viol_b15), 0);

        // Fill to full while frames hold the bus; 9th push must be dropped
        base = log_a.size();
        FrameStart = 1'b1;
        for (int i = 0; i < 9; i++) begin
            chk("fill_ready", 32'(WrReady), (i < 8) ? 1 : 0);
            WrValid = 1'b1; WrAddr = 18'h03000 + 18'(i); WrData = 15'h100 + 15'(i);
            step();
        end
        WrValid = 1'b0; FrameStart = 1'b0;
        for (int t = 0; t < 4; t++) begin
            step();
            chk("full_ready", 32'(WrReady), 0);
            chk("full_nwe", 32'(SRAM_nWE), 1);
        end
        step();
        chk("first_pop_nwe", 32'(SRAM_nWE), 0);
        chk("first_pop_ready", 32'(WrReady), 1);
        repeat (12) step();
        chk("full_count", 32'(log_a.size() - base), 8);
        for (int k = 0; k < 8; k++) begin
            chk_log("full_log", base + k, 18'h03000 + 18'(k), 16'h100 + 16'(k));
            chk("full_mem", 32'(mem[18'h03000 + 18'(k)]), 32'h100 + 32'(k));
        end
        chk("dropped_mem", 32'(mem[18'h03008]), 32'h3008);
        chk("ovl_sticky", 32'(OvlErr), 1);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        step();
        chk("ovl_cleared", 32'(OvlErr), 0);

        // Overlapping FrameStart restarts the window and sets OvlErr
        rd_a[0] = 18'h00111; rd_a[1] = 18'h00122; rd_a[2] = 18'h00133; rd_a[3] = 18'h00144;
        FrameStart = 1'b1;
        step();
        FrameStart = 1'b0;
        chk("ovl_c1", 32'(OvlErr), 0);
        step();
        FrameStart = 1'b1;
        chk("ovl_c2", 32'(OvlErr), 0);
        step();
        FrameStart = 1'b0;
        chk("ovl_c3", 32'(OvlErr), 1);
        for (int j = 0; j < 4; j++) begin
            RdAddr = rd_a[j];
            step();
            chk("ovl_rd_a", 32'(SRAM_A), 32'(rd_a[j]));
            chk("ovl_rd_noe", 32'(SRAM_nOE), 0);
        end
        step();
        chk("ovl_turn_noe", 32'(SRAM_nOE), 1);
        chk("ovl_rdq", 32'(RdQ), 32'h144);
        #2 Reset = 1'b1;
        #1;
        chk("arst_ovl", 32'(OvlErr), 0);   chk("arst_a", 32'(SRAM_A), 0);
        chk("arst_nce", 32'(SRAM_nCE), 1); chk("arst_noe", 32'(SRAM_nOE), 1);
        chk("arst_rdy", 32'(WrReady), 0);
        step();
        Reset = 1'b0;
        step();

        // Reset during a write cycle drops the pins and the queued data
        WrValid = 1'b1; WrAddr = 18'h04000; WrData = 15'h1111;
        step();
        WrValid = 1'b0;
        WrValid = 1'b1; WrAddr = 18'h04001; WrData = 15'h2222;
        step();
        WrValid = 1'b0;
        chk("mw_nwe", 32'(SRAM_nWE), 0);
        base = log_a.size();
        #2 Reset = 1'b1;
        #1;
        chk("mw_rst_nwe", 32'(SRAM_nWE), 1);
        chk("mw_rst_oe", 32'(SRAM_DQ_OE), 0);
        chk("mw_rst_dqo", 32'(SRAM_DQ_O), 0);
        step();
        Reset = 1'b0;
        repeat (6) step();
        chk("mw_no_write", 32'(log_a.size() - base), 0);
        chk("mw_mem", 32'(mem[18'h04001]), 32'h4001);

`ifdef SRAM_BANK_SWAP_EN
        // Bank swap waits for an idle bus and an empty FIFO
        base = log_a.size();
        FrameStart = 1'b1; WrValid = 1'b1; WrAddr = 18'h05000; WrData = 15'h0AAA;
        step();
        FrameStart = 1'b0; BankToggle = 1'b1; WrAddr = 18'h05001; WrData = 15'h0BBB;
        step();
        BankToggle = 1'b0; WrValid = 1'b0;
        for (int t = 0; t < 5; t++) begin
            chk("bank_hold", 32'(DispBank), 0);
            step();
        end
        repeat (4) step();
        chk("bank_flip", 32'(DispBank), 1);
        chk_log("bank_wr0", base, 18'h25000, 16'h0AAA);
        chk_log("bank_wr1", base + 1, 18'h25001, 16'h0BBB);
        WrValid = 1'b1; WrAddr = 18'h25002; WrData = 15'h0CCC;
        step();
        WrValid = 1'b0;
        repeat (3) step();
        chk_log("bank_wr2", base + 2, 18'h05002, 16'h0CCC);
        FrameStart = 1'b1;
        step();
        FrameStart = 1'b0; RdAddr = 18'h00007;
        step();
        chk("bank_rd_a", 32'(SRAM_A), 32'h20007);
        repeat (6) step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
